arb_requester: RTL

ARB_REQUESTER -- requirements
Module: arb_requester

---
 rtl/arb_requester_if.sv | 29 ++
 rtl/arb_requester.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/arb_requester_if.sv
// ------------------------------------------------------------------
// arb_requester_if : burst launch and arbiter handshake bundle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface arb_requester_if;
  logic       start;
  logic [3:0] burst_len;
  logic       req;
  logic       gnt;
  logic       beat_valid;
  logic [3:0] beat_idx;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  start, burst_len, gnt,
    output req, beat_valid, beat_idx, busy, done, err
  );

  modport slave (
    output start, burst_len, gnt,
    input  req, beat_valid, beat_idx, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/arb_requester.sv
// ------------------------------------------------------------------
// arb_requester : burst requester for a shared round-robin arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module arb_requester #(
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  arb_requester_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2,
    S_REL  = 2'd3
  } state_t;

  localparam logic [7:0] C_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     r_state;
  logic       r_req;
  logic       r_done;
  logic       r_err;
  logic       r_pending;
  logic [3:0] r_len;
  logic [3:0] r_hold_len;
  logic [3:0] r_beat_idx;
  logic [7:0] r_wait_cnt;

  logic w_busy;
  logic w_last;
  logic w_xfer;

  assign w_busy = (r_state != S_IDLE) || r_pending;
  // burst_len of 0 means 16 beats: 0 - 1 wraps to 15 in 4 bits
  assign w_last = (r_beat_idx == (r_len - 4'd1));
  assign w_xfer = r_req && bus.gnt && ((r_state == S_REQ) || (r_state == S_XFER));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_pending  <= 1'b0;
      r_len      <= 4'd0;
      r_hold_len <= 4'd0;
      r_beat_idx <= 4'd0;
      r_wait_cnt <= 8'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;

      // Later assignments in the state case override this capture
      if (bus.start && w_busy && !r_pending) begin
        r_pending  <= 1'b1;
        r_hold_len <= bus.burst_len;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_REQ;
            r_req      <= 1'b1;
            r_len      <= bus.burst_len;
            r_beat_idx <= 4'd0;
            r_wait_cnt <= 8'd0;
          end
        end

        S_REQ: begin
          if (bus.gnt) begin
            r_beat_idx <= r_beat_idx + 4'd1;
            if (w_last) begin
              r_state <= S_REL;
              r_req   <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_XFER;
            end
          end else if (r_wait_cnt == C_WAIT_LAST) begin
            r_state   <= S_IDLE;
            r_req     <= 1'b0;
            r_err     <= 1'b1;
            r_pending <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end

        S_XFER: begin
          if (bus.gnt) begin
            r_beat_idx <= r_beat_idx + 4'd1;
            if (w_last) begin
              r_state <= S_REL;
              r_req   <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            // Preempted: re-request with a fresh grant-wait budget
            r_state    <= S_REQ;
            r_wait_cnt <= 8'd0;
          end
        end

        S_REL: begin
          if (r_pending) begin
            r_state    <= S_REQ;
            r_req      <= 1'b1;
            r_len      <= r_hold_len;
            r_pending  <= 1'b0;
            r_beat_idx <= 4'd0;
            r_wait_cnt <= 8'd0;
          end else if (bus.start) begin
            r_state    <= S_REQ;
            r_req      <= 1'b1;
            r_len      <= bus.burst_len;
            r_pending  <= 1'b0;
            r_beat_idx <= 4'd0;
            r_wait_cnt <= 8'd0;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req        = r_req;
  assign bus.beat_valid = w_xfer;
  assign bus.beat_idx   = r_beat_idx;
  assign bus.busy       = w_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

`default_nettype wire
